// File: rtl/alarm_buzzer_if.sv
// +----------------------------------------------------------------------------+
// | alarm_buzzer_if : alarm level / acknowledge in, tone and status out        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface alarm_buzzer_if;
   logic       sp;
   logic       ack;
   logic       buzz;
   logic       busy;
   logic       done;
   logic [7:0] beeps;

   modport master (
      output sp,
      output ack,
      input  buzz,
      input  busy,
      input  done,
      input  beeps
   );

   modport slave (
      input  sp,
      input  ack,
      output buzz,
      output busy,
      output done,
      output beeps
   );
endinterface : alarm_buzzer_if

`default_nettype wire

// File: rtl/alarm_buzzer.sv
// +----------------------------------------------------------------------------+
// | alarm_buzzer : gates a square-wave tone into BEEP_COUNT beeps on sp rising |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module alarm_buzzer #(
   parameter int unsigned TONE_DIV     = 12500,
   parameter int unsigned BEEP_ON_CYC  = 12500000,
   parameter int unsigned BEEP_OFF_CYC = 12500000,
   parameter int unsigned BEEP_COUNT   = 5
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   alarm_buzzer_if.slave bus
);

   localparam logic [31:0] TONE_LAST  = 32'(TONE_DIV - 1);
   localparam logic [31:0] ON_LAST    = 32'(BEEP_ON_CYC - 1);
   localparam logic [31:0] OFF_LAST   = 32'(BEEP_OFF_CYC - 1);
   localparam logic [7:0]  BEEPS_LAST = 8'(BEEP_COUNT);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BEEP_ON  = 2'd1,
      BEEP_OFF = 2'd2,
      HOLD     = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        sp_dly_q, sp_dly_d;
   logic        buzz_q, buzz_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [7:0]  beeps_q, beeps_d;
   logic [31:0] tone_cnt_q, tone_cnt_d;
   logic [31:0] phase_cnt_q, phase_cnt_d;
   logic        trigger;

   // sp_dly resets low, so sp already high at reset release is a rising edge
   assign trigger = bus.sp & ~sp_dly_q;

   always_comb begin
      state_d     = state_q;
      sp_dly_d    = bus.sp;
      buzz_d      = buzz_q;
      busy_d      = busy_q;
      done_d      = done_q;
      beeps_d     = beeps_q;
      tone_cnt_d  = tone_cnt_q;
      phase_cnt_d = phase_cnt_q;

      case (state_q)
         IDLE: begin
            buzz_d = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b0;
            if (trigger) begin
               state_d     = BEEP_ON;
               buzz_d      = 1'b1;
               busy_d      = 1'b1;
               beeps_d     = 8'd1;
               tone_cnt_d  = 32'd0;
               phase_cnt_d = 32'd0;
            end
         end

         BEEP_ON, BEEP_OFF: begin
            // Abort beats ack, ack beats phase end, phase end beats tone toggle
            if (!bus.sp) begin
               state_d     = IDLE;
               buzz_d      = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b0;
               beeps_d     = 8'd0;
               tone_cnt_d  = 32'd0;
               phase_cnt_d = 32'd0;
            end else if (bus.ack) begin
               state_d     = HOLD;
               buzz_d      = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               tone_cnt_d  = 32'd0;
               phase_cnt_d = 32'd0;
            end else if (state_q == BEEP_ON) begin
               if (phase_cnt_q == ON_LAST) begin
                  state_d     = BEEP_OFF;
                  buzz_d      = 1'b0;
                  tone_cnt_d  = 32'd0;
                  phase_cnt_d = 32'd0;
               end else begin
                  phase_cnt_d = phase_cnt_q + 32'd1;
                  if (tone_cnt_q == TONE_LAST) begin
                     buzz_d     = ~buzz_q;
                     tone_cnt_d = 32'd0;
                  end else begin
                     tone_cnt_d = tone_cnt_q + 32'd1;
                  end
               end
            end else begin
               buzz_d = 1'b0;
               if (phase_cnt_q == OFF_LAST) begin
                  tone_cnt_d  = 32'd0;
                  phase_cnt_d = 32'd0;
                  if (beeps_q == BEEPS_LAST) begin
                     state_d = HOLD;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = BEEP_ON;
                     buzz_d  = 1'b1;
                     beeps_d = beeps_q + 8'd1;
                  end
               end else begin
                  phase_cnt_d = phase_cnt_q + 32'd1;
               end
            end
         end

         HOLD: begin
            buzz_d = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
            if (!bus.sp) begin
               state_d = IDLE;
               done_d  = 1'b0;
               beeps_d = 8'd0;
            end
         end

         default: begin
            state_d     = IDLE;
            buzz_d      = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            beeps_d     = 8'd0;
            tone_cnt_d  = 32'd0;
            phase_cnt_d = 32'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sp_dly_q    <= 1'b0;
         buzz_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         beeps_q     <= 8'd0;
         tone_cnt_q  <= 32'd0;
         phase_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         sp_dly_q    <= sp_dly_d;
         buzz_q      <= buzz_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         beeps_q     <= beeps_d;
         tone_cnt_q  <= tone_cnt_d;
         phase_cnt_q <= phase_cnt_d;
      end
   end

   assign bus.buzz  = buzz_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.beeps = beeps_q;

endmodule : alarm_buzzer

`default_nettype wire
